// File: rtl/jtdd_dwnld_remap.sv
// ROM download remapper: relocates loader bytes to SDRAM word/lane through a small FIFO, diverts PROM bytes.
// Optional `define JTDD_DWNLD_CHECKSUM_EN adds a 16-bit running checksum output of accepted bytes.
module jtdd_dwnld_remap #(
  parameter int          FIFO_AW    = 2,
  parameter logic [24:0] PROM_START = 25'h10_4000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        downloading,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic        ioctl_wr,
  input  logic        sdram_ack,
  output logic [21:0] prog_addr,
  output logic [7:0]  prog_data,
  output logic [1:0]  prog_mask,
  output logic        prog_we,
  output logic        prom_we,
  output logic [7:0]  prom_addr,
  output logic [3:0]  prom_data,
  output logic        dwnld_busy,
  output logic        overflow
`ifdef JTDD_DWNLD_CHECKSUM_EN
  ,
  output logic [15:0] checksum
`endif
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int EW    = 22 + 1 + 8;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

  // Handshake: prog_we rises with a fresh entry and stays high (data stable)
  // until sdram_ack is sampled; the following cycle is always idle.
  state_t state_q, state_d;

  logic [EW-1:0]    mem_q [DEPTH];
  logic [FIFO_AW:0] wr_ptr_q, rd_ptr_q;
  logic             fifo_empty, fifo_full;

  logic [21:0] dec_word;
  logic        dec_lane, dec_sd, dec_prom;
  logic        wr_sd, push, drop, pop;
  logic        dl_q, dl_rise;

  logic [21:0] prog_addr_q;
  logic [7:0]  prog_data_q;
  logic [1:0]  prog_mask_q;
  logic        prom_we_q;
  logic [7:0]  prom_addr_q;
  logic [3:0]  prom_data_q;
  logic        overflow_q;

  always_comb begin
    dec_sd   = 1'b0;
    dec_prom = 1'b0;
    dec_word = '0;
    dec_lane = 1'b0;
    if (ioctl_addr < 25'h06_0000) begin
      dec_sd   = 1'b1;
      dec_word = {1'b0, ioctl_addr[21:1]};
      dec_lane = ioctl_addr[0];
    end else if (ioctl_addr < 25'h08_0000) begin
      dec_sd   = 1'b1;
      dec_word = 22'h06_0000 + {6'd0, ioctl_addr[15:0]};
      dec_lane = ioctl_addr[16];
    end else if (ioctl_addr < 25'h10_0000) begin
      dec_sd   = 1'b1;
      dec_word = 22'h08_0000 + {4'd0, ioctl_addr[17:0]};
      dec_lane = ioctl_addr[18];
    end else if (ioctl_addr < PROM_START) begin
      dec_sd   = 1'b1;
      dec_word = 22'h0C_0000 + {9'd0, ioctl_addr[13:1]};
      dec_lane = ioctl_addr[0];
    end else if (ioctl_addr < PROM_START + 25'd256) begin
      dec_prom = 1'b1;
    end
  end

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                      (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);

  // A pop in the same cycle frees a slot, so a push at full still succeeds.
  assign wr_sd   = ioctl_wr & dec_sd;
  assign push    = wr_sd & (~fifo_full | pop);
  assign drop    = wr_sd & fifo_full & ~pop;
  assign dl_rise = downloading & ~dl_q;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (sdram_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= {dec_word, dec_lane, ioctl_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      dl_q        <= 1'b0;
      prog_addr_q <= '0;
      prog_data_q <= '0;
      prog_mask_q <= 2'b11;
      prom_we_q   <= 1'b0;
      prom_addr_q <= '0;
      prom_data_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      dl_q      <= downloading;
      prom_we_q <= ioctl_wr & dec_prom;
      if (ioctl_wr && dec_prom) begin
        prom_addr_q <= ioctl_addr[7:0];
        prom_data_q <= ioctl_data[3:0];
      end
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q    <= rd_ptr_q + 1'b1;
        prog_addr_q <= mem_q[rd_ptr_q[FIFO_AW-1:0]][EW-1:9];
        prog_mask_q <= mem_q[rd_ptr_q[FIFO_AW-1:0]][8] ? 2'b01 : 2'b10;
        prog_data_q <= mem_q[rd_ptr_q[FIFO_AW-1:0]][7:0];
      end
      // A drop in the same cycle as a new download start still counts.
      if (drop)         overflow_q <= 1'b1;
      else if (dl_rise) overflow_q <= 1'b0;
    end
  end

`ifdef JTDD_DWNLD_CHECKSUM_EN
  logic [15:0] checksum_q;
  logic        accepted;
  assign accepted = push | (ioctl_wr & dec_prom);

  always_ff @(posedge clk) begin
    if (rst) begin
      checksum_q <= '0;
    end else if (dl_rise) begin
      checksum_q <= accepted ? {8'd0, ioctl_data} : 16'd0;
    end else if (downloading && accepted) begin
      checksum_q <= checksum_q + {8'd0, ioctl_data};
    end
  end
  assign checksum = checksum_q;
`endif

  assign prog_addr  = prog_addr_q;
  assign prog_data  = prog_data_q;
  assign prog_mask  = prog_mask_q;
  assign prog_we    = (state_q == ST_WAIT);
  assign prom_we    = prom_we_q;
  assign prom_addr  = prom_addr_q;
  assign prom_data  = prom_data_q;
  assign overflow   = overflow_q;
  assign dwnld_busy = downloading | ~fifo_empty | (state_q == ST_WAIT);

endmodule

// File: tb/tb_jtdd_dwnld_remap.sv
// Scoreboard bench for jtdd_dwnld_remap: expected SDRAM/PROM writes queued at drive time, checked at output.
module tb_jtdd_dwnld_remap;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        downloading = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_data = '0;
  logic        ioctl_wr = 1'b0;
  logic        sdram_ack = 1'b0;
  logic [21:0] prog_addr;
  logic [7:0]  prog_data;
  logic [1:0]  prog_mask;
  logic        prog_we;
  logic        prom_we;
  logic [7:0]  prom_addr;
  logic [3:0]  prom_data;
  logic        dwnld_busy;
  logic        overflow;
`ifdef JTDD_DWNLD_CHECKSUM_EN
  logic [15:0] checksum;
  logic [15:0] exp_sum = '0;
`endif

  jtdd_dwnld_remap dut (
    .clk(clk), .rst(rst), .downloading(downloading),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
    .sdram_ack(sdram_ack),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask),
    .prog_we(prog_we), .prom_we(prom_we), .prom_addr(prom_addr),
    .prom_data(prom_data), .dwnld_busy(dwnld_busy), .overflow(overflow)
`ifdef JTDD_DWNLD_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  logic [11:0] prom_q[$];

  logic ack_en   = 1'b0;
  int   ack_dly  = 0;
  logic ack_rand = 1'b1;
  int   ack_cnt  = 0;
  logic we_prev  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // 0 = SDRAM region, 1 = PROM, 2 = discarded
  function automatic int region(input logic [24:0] a);
    int ai;
    ai = int'(a);
    if (ai < 'h104000) return 0;
    if (ai < 'h104100) return 1;
    return 2;
  endfunction

  function automatic logic [31:0] model(input logic [24:0] a, input logic [7:0] d);
    int ai, word, lane;
    logic [21:0] w;
    logic [1:0]  m;
    ai = int'(a);
    if (ai < 'h60000) begin
      word = ai / 2;                       lane = ai % 2;
    end else if (ai < 'h80000) begin
      word = 'h60000 + (ai % 'h10000);     lane = (ai / 'h10000) % 2;
    end else if (ai < 'h100000) begin
      word = 'h80000 + (ai % 'h40000);     lane = (ai / 'h40000) % 2;
    end else begin
      word = 'hC0000 + (ai % 'h4000) / 2;  lane = ai % 2;
    end
    w = word[21:0];
    m = (lane == 1) ? 2'b01 : 2'b10;
    return {w, m, d};
  endfunction

  // driver: called at a negedge, returns at the next negedge with ioctl_wr low
  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d, input bit keep);
    ioctl_addr = a;
    ioctl_data = d;
    ioctl_wr   = 1'b1;
    if (region(a) == 0 && keep) exp_q.push_back(model(a, d));
    if (region(a) == 1) prom_q.push_back({a[7:0], d[3:0]});
`ifdef JTDD_DWNLD_CHECKSUM_EN
    if (downloading && keep && region(a) != 2) exp_sum = exp_sum + {8'd0, d};
`endif
    @(negedge clk);
    ioctl_wr = 1'b0;
  endtask

  task automatic dl_restart();
    downloading = 1'b0;
    @(negedge clk);
    downloading = 1'b1;
    @(negedge clk);
`ifdef JTDD_DWNLD_CHECKSUM_EN
    exp_sum = '0;
`endif
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || prog_we) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) check({tag, "_timeout"}, 32'(exp_q.size()), 0);
  endtask

  // ack responder
  always @(negedge clk) begin
    sdram_ack <= 1'b0;
    if (prog_we && ack_en && !rst) begin
      if (ack_cnt >= ack_dly) begin
        sdram_ack <= 1'b1;
        ack_cnt   <= 0;
        if (ack_rand) ack_dly <= $urandom_range(0, 3);
      end else begin
        ack_cnt <= ack_cnt + 1;
      end
    end
  end

  // scoreboard monitors
  always @(negedge clk) begin
    if (prog_we && !we_prev && !rst) begin
      if (exp_q.size() == 0) check("unexpected_prog_we", 1, 0);
      else check("prog_write", {prog_addr, prog_mask, prog_data}, exp_q.pop_front());
    end
    we_prev <= prog_we;
    if (prom_we) begin
      if (prom_q.size() == 0) check("unexpected_prom_we", 1, 0);
      else check("prom_write", {20'd0, prom_addr, prom_data}, {20'd0, prom_q.pop_front()});
    end
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_prog_we", prog_we, 0);
    check("rst_mask", prog_mask, 2'b11);
    check("rst_addr", prog_addr, 0);
    check("rst_busy", dwnld_busy, 0);
    check("rst_ovf", overflow, 0);
    check("rst_prom_we", prom_we, 0);
    rst = 1'b0;
    @(negedge clk);

    // single linear write, fixed 3-cycle ack delay
    dl_restart();
    ack_rand = 1'b0; ack_dly = 3; ack_en = 1'b1;
    wr_byte(25'h00003, 8'h5A, 1);
    downloading = 1'b0;
    n = 0;
    while (!prog_we && n < 20) begin @(negedge clk); n++; end
    check("t1_we_seen", prog_we, 1);
    n = 0;
    while (prog_we && n < 20) begin @(negedge clk); n++; end
    check("t1_we_len", n, 4);
    check("t1_busy_fall", dwnld_busy, 0);
    ack_rand = 1'b1;

    // scroll then object, in order; discarded addresses produce nothing
    dl_restart();
    wr_byte(25'h70010, 8'h11, 1);
    wr_byte(25'hC0004, 8'h22, 1);
    wr_byte(25'h104100, 8'h77, 1);
    wr_byte(25'h1FFFFFF, 8'h78, 1);
    drain("t2");

    // PROM write and MCU write
    wr_byte(25'h104005, 8'hF3, 1);
    wr_byte(25'h100007, 8'h9C, 1);
    wr_byte(25'h00010, 8'hA1, 1);
    drain("t3");
    check("t3_prom_left", 32'(prom_q.size()), 0);

    // random stimulus across all regions
    for (int i = 0; i < 16; i++) begin
      logic [24:0] a;
      case ($urandom_range(0, 4))
        0: a = 25'($urandom_range(0, 'h5FFFF));
        1: a = 25'($urandom_range('h60000, 'h7FFFF));
        2: a = 25'($urandom_range('h80000, 'hFFFFF));
        3: a = 25'($urandom_range('h100000, 'h103FFF));
        default: a = 25'($urandom_range('h104000, 'h1040FF));
      endcase
      wr_byte(a, 8'($urandom_range(0, 255)), 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain("t4");

    // overflow: six writes, no acks; five fit (output register + 4 entries)
    ack_en = 1'b0;
    dl_restart();
    check("ovf_cleared", overflow, 0);
    for (int i = 0; i < 6; i++) begin
      wr_byte(25'h00100 + 25'(i), 8'(8'h40 + i), i < 5);
      if (i == 4) check("ovf_before_drop", overflow, 0);
    end
    check("ovf_set", overflow, 1);
    ack_en = 1'b1;
    drain("t5");
    check("ovf_sticky", overflow, 1);
    dl_restart();
    check("ovf_rise_clear", overflow, 0);

    // reset while in WAIT with 3 entries queued
    downloading = 1'b0;
    ack_en = 1'b0;
    for (int i = 0; i < 4; i++) wr_byte(25'h00200 + 25'(i), 8'(8'h80 + i), 1);
    repeat (2) @(negedge clk);
    check("pre_rst_we", prog_we, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
`ifdef JTDD_DWNLD_CHECKSUM_EN
    exp_sum = '0;
`endif
    check("midrst_we", prog_we, 0);
    check("midrst_busy", dwnld_busy, 0);
    check("midrst_mask", prog_mask, 2'b11);
    ack_en = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_busy", dwnld_busy, 0);

`ifdef JTDD_DWNLD_CHECKSUM_EN
    dl_restart();
    wr_byte(25'h00020, 8'h10, 1);
    wr_byte(25'h104001, 8'h25, 1);
    wr_byte(25'h1FFFFFF, 8'hEE, 1);
    drain("t7");
    check("checksum", checksum, exp_sum);
    downloading = 1'b0;
`endif

    check("sb_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/jtdd_dwnld_remap.md
Name: jtdd_dwnld_remap

Overview:
- Download-side stage that sits directly upstream of the SDRAM programming port and the priority-PROM write path.
- Takes the byte stream from the ROM loader (ioctl bus) and relocates each byte to its SDRAM word address and byte lane, using the layout the ROM slot controller reads.
- Buffers bytes in a small FIFO so that loader writes are never lost while SDRAM acknowledges slowly.
- Diverts PROM bytes to a separate write strobe. Holds the system in download-busy until everything is committed.

Parameters:
- FIFO_AW, 2, log2 of FIFO depth (default depth 4 entries).
- PROM_START, 25'h10_4000, first loader byte address of the priority PROM.

Ports:
- clk  in  1  system clock (48 MHz domain).
- rst  in  1  synchronous reset, active-high.
- downloading  in  1  loader active.
- ioctl_addr  in  25  loader byte address.
- ioctl_data  in  8  loader byte.
- ioctl_wr  in  1  one-cycle byte-valid strobe.
- sdram_ack  in  1  SDRAM accepted the current write.
- prog_addr  out  22  SDRAM word address.
- prog_data  out  8  byte to write (same value on both lanes).
- prog_mask  out  2  active-low lane mask: 2'b10 = low byte, 2'b01 = high byte.
- prog_we  out  1  write request; held until sdram_ack.
- prom_we  out  1  one-cycle PROM write strobe.
- prom_addr  out  8  PROM address.
- prom_data  out  4  PROM nibble.
- dwnld_busy  out  1  downloading or FIFO not empty or write pending.
- overflow  out  1  sticky: a byte was dropped.

Behaviour:
Address decode, for byte address a, with ioctl_wr registered in cycle 0:
- a < 0x60000: linear region. Word = a[21:1]; lane = a[0] (1 = high byte).
- 0x60000 ≤ a < 0x80000: scroll region. Word = 0x60000 + a[15:0]; lane = a[16].
- 0x80000 ≤ a < 0x100000: object region. Word = 0x80000 + a[17:0]; lane = a[18].
- 0x100000 ≤ a < PROM_START: MCU region. Word = 0xC0000 + a[13:1]; lane = a[0].
- PROM_START ≤ a < PROM_START+256: PROM region. No FIFO entry. In cycle 1: prom_we=1, prom_addr=a[7:0], prom_data=ioctl_data[3:0].
- Anything else: discarded silently, no flag.

FIFO:
- Each entry holds {word[21:0], lane, data[7:0]}.
- Push happens in cycle 1 after a decoded SDRAM-region write.
- Full: the byte is dropped and overflow is set to 1. overflow clears only on rst or on a rising edge of downloading.
- Simultaneous push and pop at full: the pop frees the slot, so the push succeeds.

Output FSM:
- IDLE: if FIFO is not empty, pop the entry to the output registers, assert prog_we, and go to WAIT. Earliest prog_we is cycle 2 after ioctl_wr.
- WAIT: hold prog_addr, prog_mask and prog_data stable with prog_we=1. On sdram_ack, deassert prog_we next cycle. If the FIFO is not empty, load the next entry one cycle later; otherwise return to IDLE. Back-to-back throughput is one write per ack + 1 cycle.

Busy:
- dwnld_busy = downloading | FIFO not empty | state==WAIT.
- After downloading falls, the FIFO drains normally and dwnld_busy falls the cycle after the last ack.

Wrap and pointers:
- Read and write pointers are FIFO_AW+1 bits and wrap naturally.
- Full when the pointer MSBs differ and the lower bits are equal.

Reset:
- Synchronous and immediate, including mid-write.
- FIFO is emptied. prog_we, prom_we, overflow and dwnld_busy go to 0; prog_addr=0; prog_data=0; prog_mask=2'b11; prom_addr=0; prom_data=0; state goes to IDLE.

Optional Feature:
JTDD_DWNLD_CHECKSUM_EN
- Defined: adds output checksum[15:0].
- checksum is the 16-bit wrapping sum of every byte accepted by decode, whether it goes to SDRAM or PROM; dropped and discarded bytes are excluded.
- It clears on rst and on a rising edge of downloading, and is frozen while downloading=0.
- Not defined: no port, no logic.

Test Plan:
- Single write ioctl_addr=0x00003, data=0x5A, ack 3 cycles later -> prog_addr=0x00001, mask=2'b01, data=0x5A, prog_we for 4 cycles, dwnld_busy falls after ack.
- Scroll 0x70010=0x11 and object 0xC0004=0x22 -> words 0x60010 with mask 2'b01, then 0x80004 with mask 2'b01; writes appear in order.
- PROM write 0x104005, data=0xF3 -> prom_we 1 cycle, prom_addr=0x05, prom_data=0x3; no prog_we.
- Six consecutive writes with sdram_ack held low -> FIFO fills; overflow=1 after the first dropped byte; after acks resume, only the stored bytes are written, in order.
- Reset asserted while in WAIT with 3 entries queued -> next cycle prog_we=0, dwnld_busy=0, no further writes.
- MCU byte 0x100007=0x9C -> prog_addr=0xC0003, mask=2'b01.
